// File: rtl/neural_simd_pkg.sv
// Shared widths and record layouts for the neural_simd issue/collect slice.
package neural_simd_pkg;

    localparam int LANES     = 4;
    localparam int LANE_W    = 8;
    localparam int WORD_W    = LANES * LANE_W;
    localparam int DEF_TAG_W = 4;

    typedef struct packed {
        logic [WORD_W-1:0]    rs1;
        logic [WORD_W-1:0]    rs2;
        logic [WORD_W-1:0]    mask;
        logic [DEF_TAG_W-1:0] tag;
    } op_t;

    typedef struct packed {
        logic [WORD_W-1:0]    rd;
        logic [DEF_TAG_W-1:0] tag;
    } res_t;

endpackage

// File: rtl/neural_sync_fifo.sv
// Synchronous FIFO with occupancy count; pointers wrap modulo DEPTH so
// non-power-of-two depths are supported. The head reads as zero when empty.
module neural_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wrap_inc(wr_ptr);
            if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/neural_simd_issue.sv
// Issue/collect stage for neural_simd: buffers operand triplets, issues one per
// cycle under result-FIFO credit, tracks in-flight ops and collects rd in order.
module neural_simd_issue
    import neural_simd_pkg::*;
#(
    parameter int IN_DEPTH  = 4,
    parameter int RES_DEPTH = 3,
    parameter int LAT       = 1,
    parameter int TAG_W     = DEF_TAG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_rs1,
    input  logic [WORD_W-1:0] in_rs2,
    input  logic [WORD_W-1:0] in_mask,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [WORD_W-1:0] simd_rs1,
    output logic [WORD_W-1:0] simd_rs2,
    output logic [WORD_W-1:0] simd_mask,
    input  logic [WORD_W-1:0] simd_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_rd,
    output logic [TAG_W-1:0]  out_tag,
    output logic [2:0]        inflight,
    output logic              busy
);

    localparam int OP_W      = 3 * WORD_W + TAG_W;
    localparam int RES_W     = WORD_W + TAG_W;
    localparam int IN_CNT_W  = $clog2(IN_DEPTH) + 1;
    localparam int RES_CNT_W = $clog2(RES_DEPTH) + 1;

    logic                 in_en;
    logic                 op_push;
    logic                 op_full;
    logic                 op_empty;
    logic [OP_W-1:0]      op_head;
    logic [IN_CNT_W-1:0]  op_count;
    logic [WORD_W-1:0]    head_rs1;
    logic [WORD_W-1:0]    head_rs2;
    logic [WORD_W-1:0]    head_mask;
    logic [TAG_W-1:0]     head_tag;
    logic                 issue;
    int                   credit_used;
    logic [LAT:0]         vpipe;
    logic [TAG_W-1:0]     tpipe [LAT+1];
    logic                 res_push;
    logic                 res_pop;
    logic                 res_full;
    logic                 res_empty;
    logic [RES_W-1:0]     res_head;
    logic [RES_CNT_W-1:0] res_count;
    logic                 unused_res_full;

    // in_en keeps in_ready low until the first clock after reset release.
    assign in_ready = in_en && !op_full;
    assign op_push  = in_valid && in_ready;

    neural_sync_fifo #(
        .WIDTH (OP_W),
        .DEPTH (IN_DEPTH)
    ) u_op_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (op_push),
        .push_data ({in_rs1, in_rs2, in_mask, in_tag}),
        .pop       (issue),
        .pop_data  (op_head),
        .full      (op_full),
        .empty     (op_empty),
        .count     (op_count)
    );

    assign {head_rs1, head_rs2, head_mask, head_tag} = op_head;
    assign inflight = 3'($countones(vpipe));

    // A result slot being popped this cycle can be re-promised to a new issue,
    // which is what lets RES_DEPTH = LAT+2 sustain one op per cycle.
    always_comb begin
        credit_used = int'(inflight) + int'(res_count) - (res_pop ? 1 : 0);
        issue       = !op_empty && (credit_used < RES_DEPTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_en     <= 1'b0;
            simd_rs1  <= '0;
            simd_rs2  <= '0;
            simd_mask <= '0;
            vpipe     <= '0;
            for (int i = 0; i <= LAT; i++) tpipe[i] <= '0;
        end else begin
            in_en <= 1'b1;
            vpipe <= {vpipe[LAT-1:0], issue};
            for (int i = LAT; i > 0; i--) tpipe[i] <= tpipe[i-1];
            if (issue) begin
                simd_rs1  <= head_rs1;
                simd_rs2  <= head_rs2;
                simd_mask <= head_mask;
                tpipe[0]  <= head_tag;
            end else begin
                simd_rs1  <= '0;
                simd_rs2  <= '0;
                simd_mask <= '0;
                tpipe[0]  <= '0;
            end
        end
    end

    assign res_push = vpipe[LAT];
    assign res_pop  = out_valid && out_ready;

    neural_sync_fifo #(
        .WIDTH (RES_W),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (res_push),
        .push_data ({simd_rd, tpipe[LAT]}),
        .pop       (res_pop),
        .pop_data  (res_head),
        .full      (res_full),
        .empty     (res_empty),
        .count     (res_count)
    );

    // The credit rule keeps the result FIFO from ever being full at capture.
    assign unused_res_full   = res_full;
    assign {out_rd, out_tag} = res_head;
    assign out_valid         = !res_empty;
    assign busy              = (op_count != '0) || (res_count != '0) || (inflight != 3'd0);

endmodule

// File: tb/tb_neural_simd_issue.sv
// Scoreboard bench for neural_simd_issue with a behavioural neural_simd stand-in.
`timescale 1ns/1ps
module tb_neural_simd_issue;
    import neural_simd_pkg::*;

    localparam int TAG_W = DEF_TAG_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WORD_W-1:0] in_rs1 = '0;
    logic [WORD_W-1:0] in_rs2 = '0;
    logic [WORD_W-1:0] in_mask = '0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic [WORD_W-1:0] simd_rs1;
    logic [WORD_W-1:0] simd_rs2;
    logic [WORD_W-1:0] simd_mask;
    logic [WORD_W-1:0] simd_rd;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WORD_W-1:0] out_rd;
    logic [TAG_W-1:0]  out_tag;
    logic [2:0]        inflight;
    logic              busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   delivered = 0;
    int   stall_cnt = 0;
    int   ready_mode = 0;
    res_t exp_q[$];
    int   out_cyc_q[$];
    logic [WORD_W-1:0] last_rd = '0;
    logic [TAG_W-1:0]  last_tag = '0;

    neural_simd_issue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_mask   (in_mask),
        .in_tag    (in_tag),
        .simd_rs1  (simd_rs1),
        .simd_rs2  (simd_rs2),
        .simd_mask (simd_mask),
        .simd_rd   (simd_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rd    (out_rd),
        .out_tag   (out_tag),
        .inflight  (inflight),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Per-lane weighted blend, rounded to nearest (0x64/0xC8 at 0x80 gives 0x96).
    function automatic logic [WORD_W-1:0] blend(input logic [WORD_W-1:0] a,
                                                 input logic [WORD_W-1:0] b,
                                                 input logic [WORD_W-1:0] m);
        logic [WORD_W-1:0] r;
        int av, bv, mv;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            av = int'(a[l*LANE_W +: LANE_W]);
            bv = int'(b[l*LANE_W +: LANE_W]);
            mv = int'(m[l*LANE_W +: LANE_W]);
            r[l*LANE_W +: LANE_W] = 8'((av * mv + bv * (255 - mv) + 127) / 255);
        end
        return r;
    endfunction

    // Behavioural neural_simd: one registered cycle from operands to rd.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) simd_rd <= '0;
        else        simd_rd <= blend(simd_rs1, simd_rs2, simd_mask);
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            2:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted output is matched against the head of the scoreboard.
    always @(negedge clk) begin
        res_t e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got rd=0x%0h tag=%0d with nothing pending at %0t",
                         out_rd, out_tag, $time);
            end else begin
                e = exp_q.pop_front();
                checkOutput("out_tag", 64'(out_tag), 64'(e.tag));
                checkOutput("out_rd", 64'(out_rd), 64'(e.rd));
            end
            last_rd  = out_rd;
            last_tag = out_tag;
            delivered++;
            out_cyc_q.push_back(cyc);
        end
    end

    task automatic applyStimulus(input logic [WORD_W-1:0] rs1, input logic [WORD_W-1:0] rs2,
                                 input logic [WORD_W-1:0] mask, input logic [TAG_W-1:0] tag,
                                 input int max_cycles, input bit must_accept, output bit accepted);
        res_t e;
        accepted = 1'b0;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_mask  = mask;
        in_tag   = tag;
        in_valid = 1'b1;
        for (int c = 0; c < max_cycles && !accepted; c++) begin
            @(negedge clk);
            if (in_ready) begin
                e.rd  = blend(rs1, rs2, mask);
                e.tag = tag;
                exp_q.push_back(e);
                accepted = 1'b1;
            end else begin
                stall_cnt++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (must_accept && !accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: tag %0d not accepted within %0d cycles", tag, max_cycles);
        end
    endtask

    task automatic waitDrain(input int max_cycles);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || busy) && c < max_cycles) begin
            @(posedge clk);
            #1;
            c++;
        end
        checkOutput("drain_pending", 64'(exp_q.size()), 64'd0);
        checkOutput("drain_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit acc;
        int acc_n, d0, found;
        logic [WORD_W-1:0] r1, r2;
        res_t e;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ctrl", 64'({in_ready, out_valid, busy, inflight}), 64'd0);
        checkOutput("reset_rd", 64'(out_rd), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_busy", 64'(busy), 64'd0);

        // 1. Single op, latency and reference value
        applyStimulus(32'h64646464, 32'hC8C8C8C8, 32'h808000FF, 4'd3, 10, 1'b1, acc);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("t1_out_valid_edge%0d", k), 64'(out_valid), 64'(k == 3));
        end
        waitDrain(50);
        checkOutput("t1_rd", 64'(last_rd), 64'h9696C864);
        checkOutput("t1_tag", 64'(last_tag), 64'd3);

        // 2. Mask endpoints
        r1 = $urandom;
        r2 = $urandom;
        applyStimulus(r1, r2, 32'hFFFFFFFF, 4'd5, 10, 1'b1, acc);
        waitDrain(50);
        checkOutput("t2_mask_ff", 64'(last_rd), 64'(r1));
        applyStimulus(r1, r2, 32'h00000000, 4'd6, 10, 1'b1, acc);
        waitDrain(50);
        checkOutput("t2_mask_00", 64'(last_rd), 64'(r2));

        // 3. Back-to-back stream
        out_cyc_q.delete();
        stall_cnt = 0;
        for (int i = 0; i < 8; i++)
            applyStimulus($urandom, $urandom, $urandom, TAG_W'(i), 10, 1'b1, acc);
        checkOutput("t3_in_ready_stalls", 64'(stall_cnt), 64'd0);
        waitDrain(100);
        checkOutput("t3_count", 64'(out_cyc_q.size()), 64'd8);
        if (out_cyc_q.size() == 8)
            checkOutput("t3_span", 64'(out_cyc_q[7] - out_cyc_q[0]), 64'd7);

        // 4. Downstream stalled, then released
        ready_mode = 1;
        @(posedge clk);
        #1;
        d0 = delivered;
        acc_n = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus($urandom, $urandom, $urandom, TAG_W'(i + 8), 3, 1'b0, acc);
            acc_n += int'(acc);
        end
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        checkOutput("t4_accepted", 64'(acc_n), 64'd7);
        checkOutput("t4_out_valid", 64'(out_valid), 64'd1);
        checkOutput("t4_in_ready", 64'(in_ready), 64'd0);
        checkOutput("t4_inflight", 64'(inflight), 64'd0);
        checkOutput("t4_held", 64'(delivered - d0), 64'd0);
        ready_mode = 0;
        waitDrain(100);
        checkOutput("t4_delivered", 64'(delivered - d0), 64'd7);

        // 5. Reset with work in flight
        ready_mode = 1;
        @(posedge clk);
        #1;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            in_rs1   = $urandom;
            in_rs2   = $urandom;
            in_mask  = $urandom;
            in_tag   = TAG_W'(c);
            in_valid = 1'b1;
            @(negedge clk);
            if (inflight == 3'd2 && out_valid) begin
                found = 1;
            end else begin
                if (in_ready) begin
                    e.rd  = blend(in_rs1, in_rs2, in_mask);
                    e.tag = in_tag;
                    exp_q.push_back(e);
                end
                @(posedge clk);
                #1;
            end
        end
        checkOutput("t5_reached_state", 64'(found), 64'd1);
        checkOutput("t5_busy_before", 64'(busy), 64'd1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("t5_ctrl_zero", 64'({in_ready, out_valid, busy, inflight, out_tag}), 64'd0);
        checkOutput("t5_rd_zero", 64'(out_rd), 64'd0);
        checkOutput("t5_simd_a_zero", 64'({simd_rs1, simd_rs2}), 64'd0);
        checkOutput("t5_simd_m_zero", 64'(simd_mask), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t5_in_ready_after", 64'(in_ready), 64'd1);
        checkOutput("t5_busy_after", 64'(busy), 64'd0);
        ready_mode = 0;
        d0 = delivered;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("t5_no_stale", 64'(delivered - d0), 64'd0);

        // 6. Pushing into a full FIFO while out_ready toggles
        ready_mode = 2;
        stall_cnt = 0;
        for (int i = 0; i < 16; i++)
            applyStimulus($urandom, $urandom, $urandom, TAG_W'($urandom_range(0, 15)), 50, 1'b1, acc);
        checkOutput("t6_saw_full", 64'(stall_cnt > 0), 64'd1);
        waitDrain(200);

        // 7. Random traffic with random backpressure and gaps
        ready_mode = 3;
        d0 = delivered;
        for (int i = 0; i < 30; i++) begin
            applyStimulus($urandom, $urandom, $urandom, TAG_W'(i), 100, 1'b1, acc);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                @(posedge clk);
                #1;
            end
        end
        waitDrain(400);
        checkOutput("t7_delivered", 64'(delivered - d0), 64'd30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
